usb_tx_engine: RTL and testbench
================================

Name: usb_tx_engine

Overview:
Parametrised full-speed/high-speed USB transmit path that replaces the separate PISO, bit stuffer, NRZI encoder and tx_fsm chain with one block. It accepts bytes over a valid/ready/last stream and serialises them LSB-first. It generates SYNC, bit-stuffs and NRZI-encodes the data, appends EOP, and owns the transceiver direction flag. It sits between the packet layer and the d_plus_out/d_minus_out pins, alongside the RX path.

Parameters:
CLKS_PER_BIT, 4, clk cycles per line bit (4 = 12 Mb/s from 48 MHz); must be ≥2.
SYNC_BITS, 8, SYNC length in bits (8 for FS, 32 for HS); pattern is SYNC_BITS-1 zeros followed by one 1.
STUFF_LIMIT, 6, consecutive 1s after which a 0 is inserted.
EOP_SE0_BITS, 2, SE0 bit times in EOP.

Ports:
clk  in  1  system clock
nRST  in  1  synchronous active-low reset
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data valid
tx_last  in  1  qualifies tx_data as final byte of packet
tx_abort  in  1  one-cycle request to terminate the current packet
tx_ready  out  1  block accepts tx_data this cycle
d_plus_out  out  1  D+ drive
d_minus_out  out  1  D- drive
tx_1_rx_0  out  1  1 = transmitting, 0 = receiving
tx_busy  out  1  state != IDLE
tx_error  out  1  one-cycle pulse on underrun or abort

Behaviour:
- Reset (already decided): one clock `clk`; reset `nRST` is synchronous and active-low. While nRST=0 at a clk edge: state=IDLE, holding register empty, ones count 0, NRZI level=J, bit timer 0.
- Reset values of outputs: tx_ready=1, d_plus_out=0, d_minus_out=0, tx_1_rx_0=0, tx_busy=0, tx_error=0.
- Reset mid-packet takes effect on the next edge; no EOP is emitted.
- Line encoding: J = (1,0), K = (0,1), SE0 = (0,0). When tx_1_rx_0=0, both pins are 0.
- Bit timer: counts 0..CLKS_PER_BIT-1 while state != IDLE. bit_strobe fires on the terminal count. The line value changes only on the cycle after bit_strobe, so each bit is held exactly CLKS_PER_BIT cycles.
- NRZI: a 0 toggles the level, a 1 holds it. The level starts at J each packet.
- Holding register: one byte plus a last flag. tx_ready = holding empty AND not closed AND state not in {EOP_SE0, EOP_J}. "closed" sets when a last byte is accepted and clears in IDLE. Accept = tx_valid & tx_ready.
- States and transitions:
  - IDLE: on accept, go to SYNC. On the next cycle tx_1_rx_0=1, tx_busy=1, and the first SYNC bit (K) is driven.
  - SYNC: emit SYNC_BITS bits. The final 1 counts as one toward the stuff count. After the last bit, load the shift register from the holding register and go to DATA.
  - DATA: emit 8 bits LSB-first. After each emitted 1, the ones count increments. When it reaches STUFF_LIMIT, go to STUFF; otherwise a 0 clears the count.
  - At a byte boundary:
    - if the holding register is full, transfer it;
    - else if tx_valid is high that cycle, bypass-load directly (counts as an accept);
    - else if the previous byte had last set, go to EOP_SE0;
    - else underrun: pulse tx_error and go to EOP_SE0.
  - STUFF: emit one 0 (level toggles), clear the count, return to DATA at the same bit position. A stuff bit owed after the final data bit is emitted before EOP.
  - EOP_SE0: drive SE0 for EOP_SE0_BITS bit times, then go to EOP_J.
  - EOP_J: drive J for one bit time, then go to IDLE. tx_1_rx_0 falls on the cycle after the final strobe.
- tx_abort in SYNC, DATA or STUFF: discard the holding register, pulse tx_error, and go to EOP_SE0 at the next bit_strobe without stuffing. tx_abort in IDLE or EOP is ignored.
- Simultaneous tx_abort and byte-boundary transfer: abort wins.
- Latency: the first SYNC bit appears 1 cycle after the accept. Bits per packet = SYNC_BITS + 8·N + stuff bits + EOP_SE0_BITS + 1.

Decomposition:
- Package usb_pkg: line_state_t {J, K, SE0}, tx_state_t {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J}, and localparams for the J/K/SE0 pin encodings.
- One sub-module, usb_tx_bit_timer (CLKS_PER_BIT counter with enable and bit_strobe output). It is reusable by the RX DPLL work.

Test Plan:
- Defaults, single byte 0x80 with last=1. Line per bit: KJKJKJKK (SYNC), then JKJKJKJJ (data), then SE0, SE0, J. Total 64 data-phase cycles, then 8 SE0 cycles and 4 J cycles. tx_1_rx_0 is high for 76 cycles.
- Byte 0xFF with last=1. After SYNC, the bit stream is 11111 0 111: K for 5 bits, J for the stuff bit, J for 3 bits. That is 17 bits before EOP, and tx_error=0.
- Three bytes 0x01, 0x02, 0x03 with tx_valid held high and last on the third. There are no gaps between bytes; tx_ready drops after the third accept and returns in IDLE. Total time is (8+24)·4 cycles before EOP.
- Two bytes without last, and no third byte offered. tx_error pulses once at the second byte boundary, then SE0, SE0, J, then IDLE.
- tx_abort mid-DATA on the 3rd bit of byte 1. At the next strobe the line goes SE0 for 2 bits, then J. tx_error pulses, and the holding register is empty afterwards (tx_ready=1 in IDLE).
- nRST=0 for one cycle mid-SYNC. On the next cycle all outputs are at reset values and tx_ready=1. A new packet then starts from level J.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types and line encodings for the USB transmit path.
// Provides line/FSM enums, pin encodings and the NRZI helper.
package usb_pkg;

   typedef enum logic [1:0] {
      J,
      K,
      SE0
   } line_state_t;

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DATA,
      STUFF,
      EOP_SE0,
      EOP_J
   } tx_state_t;

   // {d_plus, d_minus}
   localparam logic [1:0] PINS_J   = 2'b10;
   localparam logic [1:0] PINS_K   = 2'b01;
   localparam logic [1:0] PINS_SE0 = 2'b00;

   function automatic logic [1:0] line_pins(input line_state_t l);
      logic [1:0] p;
      case (l)
         J:       p = PINS_J;
         K:       p = PINS_K;
         default: p = PINS_SE0;
      endcase
      return p;
   endfunction

   // NRZI: a 1 holds the level, a 0 toggles it.
   function automatic line_state_t nrzi(input line_state_t l,
                                        input logic b);
      line_state_t n;
      if (b)
         n = l;
      else if (l == J)
         n = K;
      else
         n = J;
      return n;
   endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Line bit timer: counts 0..CLKS_PER_BIT-1 while enabled.
// Ports: clk, nRST (sync, active-low), en, bit_strobe (terminal count).
module usb_tx_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic nRST,
   input  logic en,
   output logic bit_strobe
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!nRST || !en)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign bit_strobe = en && (cnt == LAST);

endmodule

// File: rtl/usb_tx_engine.sv
// USB FS/HS transmit engine: SYNC, LSB-first serialise, stuff, NRZI, EOP.
// Ports: byte stream in (tx_data/valid/last/ready), tx_abort,
// line out (d_plus_out/d_minus_out), tx_1_rx_0, tx_busy, tx_error.
module usb_tx_engine
   import usb_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4,
   parameter int SYNC_BITS    = 8,
   parameter int STUFF_LIMIT  = 6,
   parameter int EOP_SE0_BITS = 2
) (
   input  logic       clk,
   input  logic       nRST,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   input  logic       tx_abort,
   output logic       tx_ready,
   output logic       d_plus_out,
   output logic       d_minus_out,
   output logic       tx_1_rx_0,
   output logic       tx_busy,
   output logic       tx_error
);

   localparam int SW = $clog2(SYNC_BITS + 1);
   localparam int OW = $clog2(STUFF_LIMIT + 1);
   localparam int EW = $clog2(EOP_SE0_BITS + 1);
   localparam logic [SW-1:0] SYNC_LAST = SW'(SYNC_BITS - 1);
   localparam logic [SW-1:0] SYNC_PRE  = SW'(SYNC_BITS - 2);
   localparam logic [OW-1:0] ONES_MAX  = OW'(STUFF_LIMIT);
   localparam logic [EW-1:0] EOP_LAST  = EW'(EOP_SE0_BITS - 1);

   tx_state_t   state, state_n;
   line_state_t line, line_n;
   logic [SW-1:0] sync_cnt, sync_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shift, shift_n;
   logic          cur_last, last_n;
   logic [OW-1:0] ones, ones_n, ones_i;
   logic [EW-1:0] eop_cnt, eop_n;
   logic [7:0]    hold_data, hold_data_n;
   logic          hold_full, hold_full_n;
   logic          hold_last, hold_last_n;
   logic          closed, closed_n;
   logic          abort_pend, abort_n;
   logic          err, err_n;

   logic       strobe;
   logic       in_pkt, accept, abort_now, abort_go;
   logic       adv, load_hold, load_byp, go_eop;
   logic [7:0] new_byte;
   logic       new_last;

   usb_tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk       (clk),
      .nRST      (nRST),
      .en        (state != IDLE),
      .bit_strobe(strobe)
   );

   assign in_pkt    = (state == SYNC) || (state == DATA) || (state == STUFF);
   assign tx_ready  = !hold_full && !closed &&
                      (state != EOP_SE0) && (state != EOP_J);
   assign accept    = tx_valid && tx_ready;
   assign abort_now = tx_abort && in_pkt;
   // Abort is latched until the current bit finishes, then jumps to EOP.
   assign abort_go  = strobe && in_pkt && (abort_pend || tx_abort);

   always_ff @(posedge clk) begin
      if (!nRST) begin
         state      <= IDLE;
         line       <= J;
         sync_cnt   <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         cur_last   <= 1'b0;
         ones       <= '0;
         eop_cnt    <= '0;
         hold_data  <= '0;
         hold_full  <= 1'b0;
         hold_last  <= 1'b0;
         closed     <= 1'b0;
         abort_pend <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_n;
         line       <= line_n;
         sync_cnt   <= sync_n;
         bit_idx    <= bit_n;
         shift      <= shift_n;
         cur_last   <= last_n;
         ones       <= ones_n;
         eop_cnt    <= eop_n;
         hold_data  <= hold_data_n;
         hold_full  <= hold_full_n;
         hold_last  <= hold_last_n;
         closed     <= closed_n;
         abort_pend <= abort_n;
         err        <= err_n;
      end
   end

   always_comb begin
      state_n   = state;
      line_n    = line;
      sync_n    = sync_cnt;
      bit_n     = bit_idx;
      shift_n   = shift;
      last_n    = cur_last;
      ones_n    = ones;
      ones_i    = '0;
      eop_n     = eop_cnt;
      abort_n   = abort_pend;
      err_n     = 1'b0;
      adv       = 1'b0;
      load_hold = 1'b0;
      load_byp  = 1'b0;
      go_eop    = 1'b0;
      new_byte  = hold_data;
      new_last  = hold_last;

      unique case (state)
         IDLE: begin
            if (accept) begin
               state_n = SYNC;
               line_n  = K;
               sync_n  = '0;
            end
         end
         SYNC: begin
            if (abort_go) begin
               go_eop = 1'b1;
            end else if (strobe) begin
               if (sync_cnt == SYNC_LAST) begin
                  load_hold = 1'b1;
                  // trailing SYNC 1 counts toward stuffing
                  ones_n    = OW'(1);
               end else begin
                  sync_n = sync_cnt + 1'b1;
                  line_n = nrzi(line, sync_cnt == SYNC_PRE);
               end
            end
         end
         DATA: begin
            if (abort_go) begin
               go_eop = 1'b1;
            end else if (strobe) begin
               ones_i = shift[0] ? ones + 1'b1 : '0;
               if (ones_i == ONES_MAX) begin
                  state_n = STUFF;
                  line_n  = nrzi(line, 1'b0);
                  ones_n  = '0;
               end else begin
                  ones_n = ones_i;
                  adv    = 1'b1;
               end
            end
         end
         STUFF: begin
            if (abort_go) begin
               go_eop = 1'b1;
            end else if (strobe) begin
               ones_n = '0;
               adv    = 1'b1;
            end
         end
         EOP_SE0: begin
            if (strobe) begin
               if (eop_cnt == EOP_LAST) begin
                  state_n = EOP_J;
                  line_n  = J;
               end else begin
                  eop_n = eop_cnt + 1'b1;
               end
            end
         end
         EOP_J: begin
            if (strobe) begin
               state_n = IDLE;
               line_n  = J;
            end
         end
         default: state_n = IDLE;
      endcase

      // Move to the next data bit, or handle the byte boundary.
      if (adv) begin
         if (bit_idx != 3'd7) begin
            state_n = DATA;
            bit_n   = bit_idx + 1'b1;
            shift_n = {1'b0, shift[7:1]};
            line_n  = nrzi(line, shift[1]);
         end else if (hold_full) begin
            load_hold = 1'b1;
         end else if (accept) begin
            load_byp = 1'b1;
         end else begin
            go_eop = 1'b1;
            err_n  = !cur_last;
         end
      end

      if (load_byp) begin
         new_byte = tx_data;
         new_last = tx_last;
      end

      if (load_hold || load_byp) begin
         state_n = DATA;
         bit_n   = '0;
         shift_n = new_byte;
         last_n  = new_last;
         line_n  = nrzi(line, new_byte[0]);
      end

      if (go_eop) begin
         state_n = EOP_SE0;
         line_n  = SE0;
         eop_n   = '0;
         abort_n = 1'b0;
      end

      if (abort_now) begin
         err_n = 1'b1;
         if (!abort_go)
            abort_n = 1'b1;
      end
   end

   always_comb begin
      hold_full_n = hold_full;
      hold_data_n = hold_data;
      hold_last_n = hold_last;
      closed_n    = closed;
      if (load_hold)
         hold_full_n = 1'b0;
      if (accept && !load_byp && !abort_now) begin
         hold_full_n = 1'b1;
         hold_data_n = tx_data;
         hold_last_n = tx_last;
      end
      if (accept && tx_last)
         closed_n = 1'b1;
      // An aborted packet takes no further bytes.
      if (abort_now) begin
         hold_full_n = 1'b0;
         closed_n    = 1'b1;
      end
      if (state_n == IDLE)
         closed_n = 1'b0;
   end

   assign tx_busy   = (state != IDLE);
   assign tx_1_rx_0 = tx_busy;
   assign tx_error  = err;
   assign {d_plus_out, d_minus_out} = tx_busy ? line_pins(line) : 2'b00;

endmodule

// File: tb/tb_usb_tx_engine.sv
// Directed bench for usb_tx_engine with hand-derived line patterns.
// Each pattern char is one bit time: J, K, S (SE0), O (line released).
module tb_usb_tx_engine;

   logic       clk = 1'b0;
   logic       nRST;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_abort;
   logic       tx_ready;
   logic       d_plus_out;
   logic       d_minus_out;
   logic       tx_1_rx_0;
   logic       tx_busy;
   logic       tx_error;

   int total = 0;
   int bad   = 0;
   int errs  = 0;
   logic [7:0] fb [3];

   always #5 clk = ~clk;

   usb_tx_engine dut (
      .clk        (clk),
      .nRST       (nRST),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_last    (tx_last),
      .tx_abort   (tx_abort),
      .tx_ready   (tx_ready),
      .d_plus_out (d_plus_out),
      .d_minus_out(d_minus_out),
      .tx_1_rx_0  (tx_1_rx_0),
      .tx_busy    (tx_busy),
      .tx_error   (tx_error)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {tx_busy, tx_1_rx_0, d_plus_out, d_minus_out}
   function automatic logic [3:0] enc(input byte c);
      logic [3:0] e;
      case (c)
         "J":     e = 4'b1110;
         "K":     e = 4'b1101;
         "S":     e = 4'b1100;
         default: e = 4'b0000;
      endcase
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_bits(input string tag, input string pat);
      logic [15:0] s;
      logic [3:0]  e;
      for (int i = 0; i < pat.len(); i++) begin
         s = '0;
         for (int k = 0; k < 4; k++) begin
            s = {s[11:0], tx_busy, tx_1_rx_0, d_plus_out, d_minus_out};
            if (tx_error)
               errs++;
            tick();
         end
         e = enc(pat[i]);
         chk($sformatf("%s bit%0d", tag, i), 32'(s), 32'({4{e}}));
      end
   endtask

   task automatic start(input int n, input int lidx);
      chk("ready_idle", 32'(tx_ready), 32'd1);
      errs     = 0;
      tx_valid = 1'b1;
      tx_data  = fb[0];
      tx_last  = (lidx == 0);
      tick();
      if (n == 1) begin
         tx_valid = 1'b0;
         tx_last  = 1'b0;
      end else begin
         tx_data = fb[1];
         tx_last = (lidx == 1);
      end
   endtask

   task automatic feed_rest(input int n, input int lidx);
      int   i = 1;
      int   guard = 0;
      logic acc;
      while (i < n && guard < 500) begin
         acc = tx_valid && tx_ready;
         tick();
         guard++;
         if (acc) begin
            i++;
            if (i == n) begin
               tx_valid = 1'b0;
               tx_last  = 1'b0;
            end else begin
               tx_data = fb[i];
               tx_last = (lidx == i);
            end
         end
      end
      if (i < n)
         chk("feed_timeout", 32'(i), 32'(n));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"},  32'(tx_busy),   32'd0);
      chk({tag, "_ready"}, 32'(tx_ready),  32'd1);
      chk({tag, "_txen"},  32'(tx_1_rx_0), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      nRST     = 1'b0;
      tx_valid = 1'b0;
      tx_data  = '0;
      tx_last  = 1'b0;
      tx_abort = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(tx_ready),    32'd1);
      chk("rst_dp",    32'(d_plus_out),  32'd0);
      chk("rst_dm",    32'(d_minus_out), 32'd0);
      chk("rst_txen",  32'(tx_1_rx_0),   32'd0);
      chk("rst_busy",  32'(tx_busy),     32'd0);
      chk("rst_err",   32'(tx_error),    32'd0);
      nRST = 1'b1;
      tick();

      // single byte 0x80, last
      fb[0] = 8'h80;
      start(1, 0);
      run_bits("t1", "KJKJKJKKJKJKJKJJSSJO");
      chk("t1_err", 32'(errs), 32'd0);
      chk_idle("t1");

      // 0xFF forces one stuff bit after five data 1s
      fb[0] = 8'hFF;
      start(1, 0);
      run_bits("t2", "KJKJKJKKKKKKKJJJJSSJO");
      chk("t2_err", 32'(errs), 32'd0);
      chk_idle("t2");

      // three back-to-back bytes
      fb[0] = 8'h01;
      fb[1] = 8'h02;
      fb[2] = 8'h03;
      start(3, 2);
      fork
         begin
            feed_rest(3, 2);
            chk("t3_ready_closed", 32'(tx_ready), 32'd0);
         end
         run_bits("t3", "KJKJKJKKKJKJKJKJKKJKJKJKKKJKJKJKSSJO");
      join
      chk("t3_err", 32'(errs), 32'd0);
      chk_idle("t3");

      // underrun after second byte
      fb[0] = 8'h0F;
      fb[1] = 8'hF0;
      start(2, -1);
      fork
         feed_rest(2, -1);
         run_bits("t4", "KJKJKJKKKKKKJKJKJKJKKKKKSSJO");
      join
      chk("t4_err", 32'(errs), 32'd1);
      chk_idle("t4");

      // abort during third data bit of byte 1
      fb[0] = 8'h00;
      fb[1] = 8'h00;
      start(2, 1);
      fork
         feed_rest(2, 1);
         begin
            repeat (41) tick();
            tx_abort = 1'b1;
            tick();
            tx_abort = 1'b0;
         end
         run_bits("t5", "KJKJKJKKJKJSSJO");
      join
      chk("t5_err", 32'(errs), 32'd1);
      chk_idle("t5");

      // reset mid-SYNC, then a clean packet
      fb[0] = 8'h80;
      start(1, 0);
      run_bits("t6a", "KJ");
      nRST = 1'b0;
      tick();
      nRST = 1'b1;
      chk("t6_dp",  32'(d_plus_out),  32'd0);
      chk("t6_dm",  32'(d_minus_out), 32'd0);
      chk("t6_err", 32'(tx_error),    32'd0);
      chk_idle("t6");
      fb[0] = 8'h80;
      start(1, 0);
      run_bits("t6b", "KJKJKJKKJKJKJKJJSSJO");
      chk("t6b_err", 32'(errs), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
